// File: rtl/mlp_pkg.sv
`default_nettype none
// ============================================================================
// Module : mlp_pkg
// Brief  : FC layer engine state encoding, width helpers and saturation limits
// Rev    : 1.0
// ============================================================================
package mlp_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ERR   = 3'd1,
    S_BIAS  = 3'd2,
    S_MAC   = 3'd3,
    S_SCALE = 3'd4,
    S_EMIT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Bits needed to hold a count in 0..n
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mlp_act_sat.sv
`default_nettype none
// ============================================================================
// Module : mlp_act_sat
// Brief  : Combinational rescale, optional round (MLP_ROUND_EN), ReLU/linear, saturate
// Rev    : 1.0
// ============================================================================
module mlp_act_sat
  import mlp_pkg::*;
#(
  parameter int MAC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic signed [MAC_WIDTH-1:0] i_acc,
  input  logic                        i_relu,
  output logic signed [OUT_WIDTH-1:0] o_res
);

  // One guard bit keeps the rounding add from wrapping
  localparam int SW = MAC_WIDTH + 1;
  localparam logic signed [SW-1:0] c_OUT_MAX = SW'(sat_max(OUT_WIDTH));
  localparam logic signed [SW-1:0] c_OUT_MIN = SW'(sat_min(OUT_WIDTH));

  logic signed [SW-1:0] w_acc_ext;
  logic signed [SW-1:0] w_pre;
  logic signed [SW-1:0] w_s;

  assign w_acc_ext = {i_acc[MAC_WIDTH-1], i_acc};

`ifdef MLP_ROUND_EN
  localparam logic signed [SW-1:0] c_HALF = {{(SW-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
  assign w_pre = w_acc_ext + c_HALF;
`else
  assign w_pre = w_acc_ext;
`endif

  assign w_s = w_pre >>> FRAC_BITS;

  always_comb begin
    o_res = w_s[OUT_WIDTH-1:0];
    if (i_relu && (w_s < 0)) begin
      o_res = '0;
    end else if (w_s > c_OUT_MAX) begin
      o_res = c_OUT_MAX[OUT_WIDTH-1:0];
    end else if (w_s < c_OUT_MIN) begin
      o_res = c_OUT_MIN[OUT_WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mlp_fc_layer_engine.sv
`default_nettype none
// ============================================================================
// Module : mlp_fc_layer_engine
// Brief  : Time-multiplexed single-MAC fully-connected layer; rounding via MLP_ROUND_EN
// Rev    : 1.0
// ============================================================================
module mlp_fc_layer_engine
  import mlp_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int WGT_WIDTH = 16,
  parameter int MAC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int MAX_IN    = 8,
  parameter int MAX_NEUR  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_wr_en,
  input  logic signed [IN_WIDTH-1:0]      in_data,
  input  logic [$clog2(MAX_IN+1)-1:0]     cfg_n_in,
  input  logic [$clog2(MAX_NEUR+1)-1:0]   cfg_n_neur,
  input  logic                            cfg_relu,
  input  logic                            start,
  input  logic                            wgt_valid,
  input  logic signed [WGT_WIDTH-1:0]     wgt_data,
  output logic                            wgt_ready,
  output logic                            out_valid,
  output logic signed [OUT_WIDTH-1:0]     out_data,
  output logic [$clog2(MAX_NEUR)-1:0]     out_idx,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            cfg_err
);

  localparam int c_NIN_W  = cnt_w(MAX_IN);
  localparam int c_NNEU_W = cnt_w(MAX_NEUR);
  localparam int c_IDX_W  = $clog2(MAX_NEUR);
  localparam int c_K_W    = $clog2(MAX_IN);
  localparam int c_PROD_W = IN_WIDTH + WGT_WIDTH;

  state_t                      r_state;
  logic signed [IN_WIDTH-1:0]  r_buf [MAX_IN];
  logic [c_NIN_W-1:0]          r_ptr;
  logic [c_NIN_W-1:0]          r_n_in;
  logic [c_NNEU_W-1:0]         r_n_neur;
  logic                        r_relu;
  logic [c_K_W-1:0]            r_k;
  logic [c_IDX_W-1:0]          r_idx;
  logic signed [MAC_WIDTH-1:0] r_acc;
  logic                        r_out_valid;
  logic signed [OUT_WIDTH-1:0] r_out_data;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_cfg_err;

  logic                        w_buf_we;
  logic                        w_cfg_bad;
  logic                        w_last_k;
  logic                        w_last_neur;
  logic signed [c_PROD_W-1:0]  w_prod;
  logic signed [MAC_WIDTH-1:0] w_bias_sh;
  logic signed [OUT_WIDTH-1:0] w_act;

  assign w_buf_we    = in_wr_en && (r_state == S_IDLE) && (r_ptr != c_NIN_W'(MAX_IN));
  assign w_cfg_bad   = (cfg_n_in == '0) || (cfg_n_in > c_NIN_W'(MAX_IN)) ||
                       (cfg_n_neur == '0) || (cfg_n_neur > c_NNEU_W'(MAX_NEUR));
  assign w_last_k    = (r_k == c_K_W'(r_n_in - c_NIN_W'(1)));
  assign w_last_neur = (r_idx == c_IDX_W'(r_n_neur - c_NNEU_W'(1)));
  assign w_prod      = r_buf[r_k] * wgt_data;
  assign w_bias_sh   = MAC_WIDTH'(wgt_data) <<< FRAC_BITS;

  mlp_act_sat #(
    .MAC_WIDTH (MAC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_act (
    .i_acc  (r_acc),
    .i_relu (r_relu),
    .o_res  (w_act)
  );

  // Buffer contents are don't-care after reset, so no reset term here
  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      r_buf[r_ptr[c_K_W-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_n_in      <= '0;
      r_n_neur    <= '0;
      r_relu      <= 1'b0;
      r_k         <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_buf_we) r_ptr <= r_ptr + c_NIN_W'(1);
          if (start) begin
            r_n_in   <= cfg_n_in;
            r_n_neur <= cfg_n_neur;
            r_relu   <= cfg_relu;
            r_idx    <= '0;
            if (w_cfg_bad) begin
              r_state   <= S_ERR;
              r_done    <= 1'b1;
              r_cfg_err <= 1'b1;
            end else begin
              r_state <= S_BIAS;
              r_busy  <= 1'b1;
            end
          end
        end
        S_ERR: begin
          r_ptr   <= '0;
          r_state <= S_IDLE;
        end
        S_BIAS: begin
          if (wgt_valid) begin
            r_acc   <= w_bias_sh;
            r_k     <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          if (wgt_valid) begin
            r_acc <= r_acc + MAC_WIDTH'(w_prod);
            if (w_last_k) r_state <= S_SCALE;
            else          r_k     <= r_k + c_K_W'(1);
          end
        end
        S_SCALE: begin
          r_out_data  <= w_act;
          r_out_valid <= 1'b1;
          r_state     <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_last_neur) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_idx   <= r_idx + c_IDX_W'(1);
              r_state <= S_BIAS;
            end
          end
        end
        S_DONE: begin
          r_ptr   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wgt_ready = (r_state == S_BIAS) || (r_state == S_MAC);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_mlp_fc_layer_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_mlp_fc_layer_engine
// Brief  : Directed bench with arithmetic reference model for mlp_fc_layer_engine
// Rev    : 1.0
// ============================================================================
module tb_mlp_fc_layer_engine;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_wr_en;
  logic signed [15:0] in_data;
  logic [3:0]         cfg_n_in;
  logic [4:0]         cfg_n_neur;
  logic               cfg_relu;
  logic               start;
  logic               wgt_valid;
  logic signed [15:0] wgt_data;
  logic               wgt_ready;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic [3:0]         out_idx;
  logic               out_ready;
  logic               busy;
  logic               done;
  logic               cfg_err;

  always #5 clk = ~clk;

  mlp_fc_layer_engine dut (
    .clk        (clk),
    .rst        (rst),
    .in_wr_en   (in_wr_en),
    .in_data    (in_data),
    .cfg_n_in   (cfg_n_in),
    .cfg_n_neur (cfg_n_neur),
    .cfg_relu   (cfg_relu),
    .start      (start),
    .wgt_valid  (wgt_valid),
    .wgt_data   (wgt_data),
    .wgt_ready  (wgt_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int g_x [8];
  int g_w [16][9];
  int q_data [$];
  int q_idx  [$];
  bit stall_en   = 1'b0;
  bit seen_valid = 1'b0;
  int valid_cyc  = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact integer sum, 32-bit wrap, Q8 rescale, activation clamp
  function automatic int model(input int n, input int xs[8], input int ws[9], input bit relu);
    longint acc;
    acc = longint'(ws[0]) * 256;
    for (int i = 0; i < n; i++) acc += longint'(xs[i]) * longint'(ws[i+1]);
    acc = longint'(int'(acc));
`ifdef MLP_ROUND_EN
    acc += 128;
`endif
    acc = acc >>> 8;
    if (relu && acc < 0) return 0;
    if (acc > 32767)     return 32767;
    if (acc < -32768)    return -32768;
    return int'(acc);
  endfunction

  // Output compare: every handshake against the model queue, holds during stalls
  initial begin
    bit p_hold = 1'b0;
    int p_data = 0;
    int p_idx  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_hold = 1'b0;
      end else begin
        if (p_hold) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, p_data);
          chk("hold_idx", out_idx, p_idx);
        end
        if (out_valid) chk("wgt_ready_low_in_emit", wgt_ready, 0);
        if (out_valid && !seen_valid) begin
          seen_valid = 1'b1;
          valid_cyc  = cyc;
        end
        if (out_valid && out_ready) begin
          if (q_data.size() == 0) chk("unexpected_output", 1, 0);
          else begin
            chk("out_data", out_data, q_data.pop_front());
            chk("out_idx", out_idx, q_idx.pop_front());
          end
        end
        p_hold = out_valid && !out_ready;
        p_data = out_data;
        p_idx  = out_idx;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_en && out_valid && out_idx == 4'd1) begin
        out_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        stall_en  = 1'b0;
      end
    end
  end

  task automatic send_wgt(input int w);
    int n = 0;
    wgt_valid = 1'b1;
    wgt_data  = 16'(w);
    while (!wgt_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) chk("wgt_ready_timeout", 0, 1);
    @(posedge clk); #1;
    wgt_valid = 1'b0;
  endtask

  task automatic run_layer(input int n_in, input int n_neur, input bit relu,
                           input bit do_stall, output int start_cyc);
    int n = 0;
    for (int i = 0; i < n_in; i++) begin
      in_wr_en = 1'b1; in_data = 16'(g_x[i]);
      @(posedge clk); #1;
    end
    in_wr_en   = 1'b0;
    cfg_n_in   = 4'(n_in);
    cfg_n_neur = 5'(n_neur);
    cfg_relu   = relu;
    for (int j = 0; j < n_neur; j++) begin
      q_data.push_back(model(n_in, g_x, g_w[j], relu));
      q_idx.push_back(j);
    end
    seen_valid = 1'b0;
    stall_en   = do_stall;
    start = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    start_cyc = cyc;
    chk("busy_after_start", busy, 1);
    for (int j = 0; j < n_neur; j++)
      for (int i = 0; i <= n_in; i++) send_wgt(g_w[j][i]);
    while (!done && n < 200) begin @(posedge clk); #1; n++; end
    chk("done_seen", done, 1);
    chk("cfg_err_clear", cfg_err, 0);
    chk("busy_at_done", busy, 0);
    chk("queue_drained", q_data.size(), 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    int sc;
    int ws1 [9];
    rst = 1'b1; in_wr_en = 1'b0; in_data = '0; cfg_n_in = '0; cfg_n_neur = '0;
    cfg_relu = 1'b0; start = 1'b0; wgt_valid = 1'b0; wgt_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0); chk("rst_out_valid", out_valid, 0);
    chk("rst_wgt_ready", wgt_ready, 0); chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Pin the model to hand-computed values
    g_x[0] = -256; g_x[1] = 512;
    ws1 = '{256, 256, 128, 0, 0, 0, 0, 0, 0};
    chk("pin_model_relu_pos", model(2, g_x, ws1, 1'b1), 256);
    ws1 = '{-512, 256, 256, 0, 0, 0, 0, 0, 0};
    chk("pin_model_linear_neg", model(2, g_x, ws1, 1'b0), -256);

    g_w[0] = '{256, 256, 128, 0, 0, 0, 0, 0, 0};
    run_layer(2, 1, 1'b1, 1'b0, sc);
    chk("first_valid_latency", valid_cyc - sc, 4);
    chk("lit_relu_pos", out_data, 256);
    chk("lit_idx0", out_idx, 0);

    g_w[0] = '{-512, 256, 256, 0, 0, 0, 0, 0, 0};
    run_layer(2, 1, 1'b1, 1'b0, sc);
    chk("lit_relu_clip0", out_data, 0);
    run_layer(2, 1, 1'b0, 1'b0, sc);
    chk("lit_linear_neg", out_data, -256);

    g_x[0] = 32767; g_x[1] = 32767;
    g_w[0] = '{0, 32767, 32767, 0, 0, 0, 0, 0, 0};
    run_layer(2, 1, 1'b1, 1'b0, sc);
    chk("lit_sat_pos", out_data, 32767);
    g_w[0] = '{0, -32767, -32767, 0, 0, 0, 0, 0, 0};
    run_layer(2, 1, 1'b0, 1'b0, sc);
    chk("lit_sat_neg", out_data, -32768);

    g_x[0] = 3;
    g_w[0] = '{0, 128, 0, 0, 0, 0, 0, 0, 0};
    run_layer(1, 1, 1'b0, 1'b0, sc);
`ifdef MLP_ROUND_EN
    chk("lit_round_pos", out_data, 2);
`else
    chk("lit_trunc_pos", out_data, 1);
`endif
    g_w[0] = '{0, -128, 0, 0, 0, 0, 0, 0, 0};
    run_layer(1, 1, 1'b0, 1'b0, sc);
`ifdef MLP_ROUND_EN
    chk("lit_round_neg", out_data, -1);
`else
    chk("lit_trunc_neg", out_data, -2);
`endif

    // Full-depth inputs, 4 neurons, back-pressure on neuron 1
    for (int i = 0; i < 8; i++) g_x[i] = (i + 1) * 97 - 400;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 9; i++) g_w[j][i] = ((j * 37 + i * 59) % 512) - 256;
    run_layer(8, 4, 1'b0, 1'b1, sc);
    chk("stall_consumed", stall_en, 0);

    // Maximum neuron count
    g_x[0] = 1000;
    for (int j = 0; j < 16; j++) begin
      g_w[j][0] = j * 20 - 160;
      g_w[j][1] = 300 - j * 40;
    end
    run_layer(1, 16, 1'b1, 1'b0, sc);
    chk("lit_last_idx", out_idx, 15);

    // Out-of-range configurations
    for (int t = 0; t < 4; t++) begin
      int ni;
      int nn;
      ni = (t == 0) ? 0 : (t == 1) ? 9 : 1;
      nn = (t == 2) ? 0 : (t == 3) ? 17 : 1;
      cfg_n_in = 4'(ni); cfg_n_neur = 5'(nn); cfg_relu = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("err_done", done, 1);
      chk("err_flag", cfg_err, 1);
      chk("err_wgt_ready", wgt_ready, 0);
      @(posedge clk); #1;
      chk("err_done_pulse", done, 0);
      chk("err_flag_pulse", cfg_err, 0);
      chk("err_wgt_ready_after", wgt_ready, 0);
    end

    // Reset in the middle of the MAC phase
    g_x[0] = 100; g_x[1] = 200;
    for (int i = 0; i < 2; i++) begin
      in_wr_en = 1'b1; in_data = 16'(g_x[i]);
      @(posedge clk); #1;
    end
    in_wr_en = 1'b0;
    cfg_n_in = 4'd2; cfg_n_neur = 5'd1; cfg_relu = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_wgt(10);
    send_wgt(20);
    chk("mid_mac_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_wgt_ready", wgt_ready, 0);
    chk("rst_mid_out_valid", out_valid, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rst_mid_no_done", done, 0);
    end

    g_x[0] = -256; g_x[1] = 512;
    g_w[0] = '{256, 256, 128, 0, 0, 0, 0, 0, 0};
    run_layer(2, 1, 1'b1, 1'b0, sc);
    chk("lit_after_reset", out_data, 256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
